// File: rtl/ad_pkg.sv
// Shared types and timing defaults for the ADC conversion scheduler.
package ad_pkg;

    // Scheduler FSM states, one conversion walks through them in order.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        WAITB = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } ad_state_t;

    // Default conversion timing, in system clocks.
    localparam int CONVST_W_DEF = 4;
    localparam int RD_W_DEF     = 3;
    localparam int TMO_DEF      = 255;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority encoder: picks the lowest requesting index at or
// after ptr, wrapping past NCH-1 back to 0. Purely combinational.
module rr_arb
    import ad_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int CH_W = ch_w(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt,
    output logic            any
);

    // Scan from ptr upwards; the first set request wins.
    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!found && req[idx]) begin
                gnt   = CH_W'(idx);
                found = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/ad_conv_sched.sv
// Shares one ADC front-end between NCH request channels: round-robin grant,
// CONVST pulse, wait for BUSY, RD strobe, then a one-cycle tagged sample.
module ad_conv_sched
    import ad_pkg::*;
#(
    parameter  int NCH      = 4,
    parameter  int DW       = 16,
    parameter  int CONVST_W = CONVST_W_DEF,
    parameter  int RD_W     = RD_W_DEF,
    parameter  int TMO      = TMO_DEF,
    localparam int CH_W     = ch_w(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_ad_enble,
    input  logic [NCH-1:0]  ad_start,
    output logic            adc_convst,
    input  logic            adc_busy,
    output logic            adc_rd_n,
    input  logic [DW-1:0]   adc_data,
    output logic            smp_valid,
    output logic [CH_W-1:0] smp_ch,
    output logic [DW-1:0]   smp_data,
    output logic            smp_err,
    output logic [NCH-1:0]  ovf,
    output logic            sched_busy
);

    ad_state_t       state;
    logic [NCH-1:0]  start_q;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  edge_v;
    logic [NCH-1:0]  clr;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gsel;
    logic [CH_W-1:0] arb_gnt;
    logic            arb_any;
    logic            grant;
    logic            busy_m;
    logic            busy_s;
    logic            busy_seen;
    logic [7:0]      ph_cnt;
    logic [7:0]      tmo_cnt;

    rr_arb #(.NCH(NCH)) u_arb (
        .req (pend),
        .ptr (ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    // A request is a rising edge of ad_start; the previous-value register
    // keeps tracking while disabled so re-enabling never fakes an edge.
    assign edge_v = ad_start & ~start_q;
    assign grant  = reg_ad_enble && (state == IDLE) && arb_any;
    assign clr    = grant ? (NCH'(1) << arb_gnt) : '0;
    assign sched_busy = (state != IDLE);

    // Edge-detect history and the two-flop BUSY synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            busy_m  <= 1'b0;
            busy_s  <= 1'b0;
        end else begin
            start_q <= ad_start;
            busy_m  <= adc_busy;
            busy_s  <= busy_m;
        end
    end

    // Pending requests and sticky overrun; a new edge in the grant cycle
    // re-arms the bit instead of counting as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
        end else if (!reg_ad_enble) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= (pend & ~clr) | edge_v;
            ovf  <= ovf | (edge_v & pend & ~clr);
        end
    end

    // Conversion sequencer with registered ADC strobes and sample outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gsel       <= '0;
            busy_seen  <= 1'b0;
            ph_cnt     <= '0;
            tmo_cnt    <= '0;
            adc_convst <= 1'b0;
            adc_rd_n   <= 1'b1;
            smp_valid  <= 1'b0;
            smp_ch     <= '0;
            smp_data   <= '0;
            smp_err    <= 1'b0;
        end else if (!reg_ad_enble) begin
            state      <= IDLE;
            adc_convst <= 1'b0;
            adc_rd_n   <= 1'b1;
            smp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gsel       <= arb_gnt;
                        ptr        <= (arb_gnt == CH_W'(NCH - 1)) ? '0 : arb_gnt + 1'b1;
                        busy_seen  <= 1'b0;
                        ph_cnt     <= '0;
                        adc_convst <= 1'b1;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    // A short BUSY pulse may come and go while CONVST is high.
                    if (busy_s) busy_seen <= 1'b1;
                    if (ph_cnt == 8'(CONVST_W - 1)) begin
                        adc_convst <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= WAITB;
                    end else begin
                        ph_cnt <= ph_cnt + 8'd1;
                    end
                end
                WAITB: begin
                    if (busy_seen && !busy_s) begin
                        adc_rd_n <= 1'b0;
                        ph_cnt   <= '0;
                        state    <= READ;
                    end else begin
                        if (busy_s) busy_seen <= 1'b1;
                        // tmo_cnt counts completed WAITB cycles; abort on the TMO-th.
                        if (tmo_cnt == 8'(TMO - 1)) begin
                            smp_valid <= 1'b1;
                            smp_err   <= 1'b1;
                            smp_data  <= '0;
                            smp_ch    <= gsel;
                            state     <= DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                end
                READ: begin
                    if (ph_cnt == 8'(RD_W - 1)) begin
                        adc_rd_n  <= 1'b1;
                        smp_valid <= 1'b1;
                        smp_err   <= 1'b0;
                        smp_data  <= adc_data;
                        smp_ch    <= gsel;
                        state     <= DONE;
                    end else begin
                        ph_cnt <= ph_cnt + 8'd1;
                    end
                end
                DONE: begin
                    smp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_conv_sched.sv
// Bench for ad_conv_sched: directed table, hand-written corner sequences and
// randomized request rounds checked against a round-robin reference model.
module tb_ad_conv_sched;

    localparam int NCH      = 4;
    localparam int DW       = 16;
    localparam int CONVST_W = 4;
    localparam int RD_W     = 3;
    localparam int TMO      = 255;
    localparam int W        = 2 + 1 + DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            reg_ad_enble = 1'b1;
    logic [NCH-1:0]  ad_start = '0;
    logic            adc_convst;
    logic            adc_busy = 1'b0;
    logic            adc_rd_n;
    logic [DW-1:0]   adc_data = '0;
    logic            smp_valid;
    logic [1:0]      smp_ch;
    logic [DW-1:0]   smp_data;
    logic            smp_err;
    logic [NCH-1:0]  ovf;
    logic            sched_busy;

    ad_conv_sched #(.NCH(NCH), .DW(DW), .CONVST_W(CONVST_W), .RD_W(RD_W), .TMO(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_ad_enble (reg_ad_enble),
        .ad_start     (ad_start),
        .adc_convst   (adc_convst),
        .adc_busy     (adc_busy),
        .adc_rd_n     (adc_rd_n),
        .adc_data     (adc_data),
        .smp_valid    (smp_valid),
        .smp_ch       (smp_ch),
        .smp_data     (smp_data),
        .smp_err      (smp_err),
        .ovf          (ovf),
        .sched_busy   (sched_busy)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] word_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC model: BUSY rises one clock after CONVST is seen, stays high
    // busy_len clocks, then the programmed word appears on the data bus.
    int            busy_len = 20;
    logic          stuck = 1'b0;
    logic          convst_d = 1'b0;
    int            btimer = 0;
    logic [DW-1:0] cur_word = '0;
    always @(posedge clk) begin
        convst_d <= adc_convst;
        if (adc_convst && !convst_d) begin
            if (!stuck) begin
                adc_busy <= 1'b1;
                btimer   <= busy_len;
                if (word_q.size() > 0) cur_word = word_q.pop_front();
                else cur_word = '0;
            end
        end else if (btimer > 0) begin
            btimer <= btimer - 1;
            if (btimer == 1) begin
                adc_busy <= 1'b0;
                adc_data <= cur_word;
            end
        end
    end

    // Scoreboard and strobe-width monitor, sampled on the falling edge.
    logic width_chk = 1'b1;
    int   cv_run = 0;
    int   rd_run = 0;
    int   rd_low_cnt = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!adc_rd_n) rd_low_cnt++;
        if (!width_chk) begin
            cv_run = 0;
            rd_run = 0;
        end else begin
            if (adc_convst) cv_run++;
            else if (cv_run != 0) begin
                chk("convst_width", cv_run, CONVST_W);
                cv_run = 0;
            end
            if (!adc_rd_n) rd_run++;
            else if (rd_run != 0) begin
                chk("rd_width", rd_run, RD_W);
                rd_run = 0;
            end
        end
        if (rst_n && smp_valid) begin
            chk("smp_one_cycle", prev_v, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample: got ch=%0d data=%0h err=%0b expected none", smp_ch, smp_data, smp_err);
            end else begin
                chk("sample", {smp_ch, smp_err, smp_data}, exp_q.pop_front());
            end
        end
        prev_v = smp_valid;
    end

    // Driver: hold a request mask high across two rising clock edges.
    task automatic pulse(input logic [NCH-1:0] m);
        @(negedge clk);
        ad_start = m;
        @(negedge clk);
        @(negedge clk);
        ad_start = '0;
    endtask

    task automatic expect_sample(input int ch, input logic [DW-1:0] w);
        word_q.push_back(w);
        exp_q.push_back({2'(ch), 1'b0, w});
    endtask

    // Wait for all expected samples and an idle scheduler, bounded.
    task automatic drain(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || sched_busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, (t < budget), 1);
        if (t >= budget) exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [NCH-1:0] mask;
        int             busy;
        int             n;
        logic [7:0]     order;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int            t;
        int            model_ptr;
        logic [DW-1:0] w;
        logic          saw_busy;

        // Directed rounds; order packs grant sequence two bits per grant, first in [1:0].
        tbl[0] = '{mask: 4'b1000, busy: 20, n: 1, order: 8'h03};
        tbl[1] = '{mask: 4'b1111, busy: 12, n: 4, order: 8'hE4};
        tbl[2] = '{mask: 4'b1010, busy: 1,  n: 2, order: 8'h0D};
        tbl[3] = '{mask: 4'b0110, busy: 2,  n: 2, order: 8'h09};
        tbl[4] = '{mask: 4'b1001, busy: 30, n: 2, order: 8'h03};
        tbl[5] = '{mask: 4'b0101, busy: 5,  n: 2, order: 8'h02};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_convst", adc_convst, 0);
        chk("rst_rd_n", adc_rd_n, 1);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_smp_ch", smp_ch, 0);
        chk("rst_smp_data", smp_data, 0);
        chk("rst_smp_err", smp_err, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sched_busy", sched_busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single request with latency check
        busy_len = 20;
        expect_sample(0, 16'h1234);
        @(negedge clk);
        ad_start = 4'b0001;
        @(negedge clk);
        chk("lat_edge_cycle", adc_convst, 0);
        @(negedge clk);
        chk("lat_grant_cycle", adc_convst, 1);
        ad_start = '0;
        drain("single_drain", 500);

        // Table-driven simultaneous requests
        foreach (tbl[i]) begin
            busy_len = tbl[i].busy;
            for (int j = 0; j < tbl[i].n; j++) begin
                w = 16'($urandom);
                expect_sample(int'(tbl[i].order[2*j +: 2]), w);
            end
            pulse(tbl[i].mask);
            drain("table_drain", 2000);
        end

        // Timeout: BUSY never rises, then a normal request
        stuck = 1'b1;
        rd_low_cnt = 0;
        exp_q.push_back({2'd1, 1'b1, 16'h0000});
        pulse(4'b0010);
        t = 0;
        while (!smp_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_latency", t, CONVST_W + TMO);
        drain("tmo_drain", 100);
        chk("tmo_no_rd", rd_low_cnt, 0);
        stuck = 1'b0;
        busy_len = 10;
        expect_sample(3, 16'hBEEF);
        pulse(4'b1000);
        drain("after_tmo_drain", 500);

        // Overrun: ch2 requests twice during a long ch0 conversion
        busy_len = 60;
        expect_sample(0, 16'h0A0A);
        expect_sample(2, 16'h2C2C);
        pulse(4'b0001);
        repeat (5) @(negedge clk);
        pulse(4'b0100);
        repeat (3) @(negedge clk);
        pulse(4'b0100);
        @(negedge clk);
        chk("ovf_set", ovf, 4'b0100);
        drain("ovf_drain", 1000);
        chk("ovf_sticky", ovf, 4'b0100);

        // Disable on the second RD cycle, with ch2 also pending
        width_chk = 1'b0;
        busy_len = 10;
        word_q.push_back(16'h5555);
        pulse(4'b0001);
        pulse(4'b0100);
        t = 0;
        while (adc_rd_n && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("dis_rd_seen", (t < 200), 1);
        @(negedge clk);
        reg_ad_enble = 1'b0;
        @(negedge clk);
        chk("dis_rd_n", adc_rd_n, 1);
        chk("dis_busy", sched_busy, 0);
        chk("dis_ovf", ovf, 0);
        chk("dis_valid", smp_valid, 0);
        pulse(4'b0010);
        @(negedge clk);
        ad_start = 4'b1000;
        @(negedge clk);
        reg_ad_enble = 1'b1;
        saw_busy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (sched_busy) saw_busy = 1'b1;
        end
        chk("reenable_no_request", saw_busy, 0);
        ad_start = '0;
        repeat (3) @(negedge clk);
        width_chk = 1'b1;

        // Second ch1 edge lands in the exact cycle ch1 is granted
        busy_len = 15;
        expect_sample(0, 16'h1111);
        expect_sample(1, 16'h2222);
        expect_sample(1, 16'h3333);
        pulse(4'b0001);
        pulse(4'b0010);
        t = 0;
        while (!smp_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("eag_first_sample", (t < 500), 1);
        @(negedge clk);
        ad_start = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        ad_start = '0;
        drain("eag_drain", 1000);
        chk("eag_ovf", ovf, 0);

        // Asynchronous reset in the middle of a conversion
        width_chk = 1'b0;
        busy_len = 30;
        expect_sample(2, 16'h7777);
        pulse(4'b0100);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_convst", adc_convst, 0);
        chk("arst_rd_n", adc_rd_n, 1);
        chk("arst_valid", smp_valid, 0);
        chk("arst_ch", smp_ch, 0);
        chk("arst_data", smp_data, 0);
        chk("arst_err", smp_err, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_busy", sched_busy, 0);
        exp_q.delete();
        word_q.delete();
        repeat (60) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        width_chk = 1'b1;

        // Random rounds against the round-robin model
        model_ptr = 0;
        for (int r = 0; r < 20; r++) begin
            logic [NCH-1:0] m;
            int last;
            m = NCH'($urandom_range(1, 15));
            busy_len = $urandom_range(1, 40);
            last = model_ptr;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (model_ptr + k) % NCH;
                if (m[c]) begin
                    w = 16'($urandom);
                    expect_sample(c, w);
                    last = c;
                end
            end
            model_ptr = (last + 1) % NCH;
            pulse(m);
            drain("rand_drain", 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad_conv_sched.md
Name: ad_conv_sched

Overview:
- Schedules one shared ADC front-end among NCH sample-request channels.
- Requests come from the per-channel ad_start strobes of the sampling-rate generator.
- Per conversion: round-robin grant, drive CONVST, wait on BUSY, read the result word with a RD strobe.
- Emits a one-cycle tagged sample to the downstream buffer; flags overrun and ADC timeout per channel.

Parameters:
- NCH, 4: number of request channels (2..8).
- DW, 16: ADC data width.
- CONVST_W, 4: CONVST high width, clocks (>=1).
- RD_W, 3: RD low width, clocks (>=1); data sampled on the last RD_W cycle.
- TMO, 255: max clocks in WAIT_BUSY before abort (8-bit counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- reg_ad_enble  in  1  host enable; 0 = clear and idle
- ad_start  in  NCH  per-channel request strobes (level, 2 clocks wide)
- adc_convst  out  1  conversion start to ADC
- adc_busy  in  1  ADC busy (high while converting); synchronised internally with a 2-FF synchroniser
- adc_rd_n  out  1  read strobe, active-low
- adc_data  in  DW  ADC parallel data
- smp_valid  out  1  one-cycle sample strobe
- smp_ch  out  clog2(NCH)  channel index of the sample
- smp_data  out  DW  sample value
- smp_err  out  1  sample aborted by timeout; smp_data = 0
- ovf  out  NCH  sticky overrun per channel
- sched_busy  out  1  FSM not in IDLE

Behaviour:
Reset values:
- adc_convst=0, adc_rd_n=1, smp_valid=0, smp_ch=0, smp_data=0, smp_err=0, ovf=0, sched_busy=0.
- Pending bits 0; round-robin pointer 0.

Requests:
- Rising-edge detect on each ad_start bit (registered previous value). An edge sets pend[i].
- Edge while pend[i] already set: ovf[i] <= 1 (sticky). pend stays 1; the request is merged.
- Edge in the same cycle that pend[i] is cleared by grant: pend[i] stays 1; the new request wins.

Arbitration:
- In IDLE with any pend set, grant the lowest index at or after ptr (wrapping).
- On grant: clear pend[g], latch g, set ptr = g+1 mod NCH.
- Grant is decided in 1 cycle.

FSM: IDLE -> CONV -> WAITB -> READ -> DONE -> IDLE.
- CONV: adc_convst=1 for exactly CONVST_W clocks, then -> WAITB.
- WAITB:
  - Wait for synchronised busy to rise then fall.
  - A busy pulse already over before entry counts if it was seen high at any time during CONV.
  - On fall -> READ.
  - Timeout counter reaches TMO -> DONE with err=1 (no RD issued).
- READ: adc_rd_n=0 for RD_W clocks; adc_data captured on the last cycle; adc_rd_n returns high the following cycle. Then -> DONE.
- DONE: smp_valid=1 for one cycle with smp_ch=g, smp_data, smp_err. Then -> IDLE.
  - smp_data/smp_ch/smp_err hold their values until the next DONE.

Latency:
- ad_start edge to CONVST rise: 2 clocks when idle (edge detect + grant).
- Back-to-back grants: no dead cycle beyond DONE.

Disable:
- reg_ad_enble=0 in any state: next cycle state=IDLE; convst=0, rd_n=1; pend cleared; ovf cleared; no smp_valid.
- Edges are ignored while disabled.
- Re-enable with ad_start already high: no request is generated until the next rising edge. The edge detector's previous-value register keeps tracking while disabled.

Async reset mid-conversion: all outputs return to reset values immediately.

Decomposition:
- Package ad_pkg:
  - state encoding enum (IDLE, CONV, WAITB, READ, DONE)
  - CH_W = clog2(NCH) function
  - default timing constants CONVST_W/RD_W/TMO
- One sub-module: rr_arb (NCH-wide round-robin priority encoder).
  - Inputs: req vector, ptr. Outputs: gnt index, any.
  - Combinational, with the ptr register inside ad_conv_sched.

Test Plan:
- Single request: enable=1, ad_start[0] high for 2 clocks, ADC model busy=20 clocks, data=16'h1234 -> convst high 4 clocks, 2 clocks after edge; rd_n low 3 clocks; smp_valid 1 clock with ch=0, data=16'h1234, err=0.
- Simultaneous requests: edges on ch 0,1,2,3 in the same cycle, ptr=0 -> samples emitted in order 0,1,2,3; next simultaneous 1,3 with ptr=0 -> order 1,3 (ptr starts at 0 after 3), then ptr=0.
- Overrun: ch2 edges twice while a long ch0 conversion is busy -> ovf[2]=1, only one ch2 sample; ovf[2] stays 1 until enable drops.
- Timeout: busy held low forever -> after CONVST_W+TMO clocks smp_valid with err=1, data=0, adc_rd_n never low; the next request proceeds normally.
- Disable mid-READ: drop enable on the 2nd RD cycle -> rd_n=1 next clock, no smp_valid, pend/ovf=0, sched_busy=0.
- Edge at grant: ch1 second edge in the exact cycle ch1 is granted -> two ch1 samples, ovf[1]=0.
